// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit unsigned multiply / divide unit.
// MUL/MULHU use a shift-add multiplier and DIVU/REMU use a restoring divider.
// Both share one 64-bit {hi, lo} working register, and each op takes 32 steps.
// When the op finishes, its result goes out on a one-cycle register-file write port.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  dest_addr,
    output logic        busy,
    output logic        reg_write,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_dest;
    logic [31:0] r_hi, r_lo;
    logic        r_reg_write;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd_data;

    logic        w_last;
    logic [32:0] w_madd;
    logic [31:0] w_mul_hi, w_mul_lo;
    logic [32:0] w_rem_sh;
    logic        w_dok;
    logic [31:0] w_dsub;
    logic [31:0] w_div_hi, w_div_lo;
    logic [31:0] w_hi_nxt, w_lo_nxt;
    logic [31:0] w_result;

    // The counter is cleared on accept, so a value of 31 marks the edge that completes step 32.
    assign w_last = (r_cnt == 6'd31);

    // Multiply step: {hi, lo} starts as {0, B}.
    // Add A into hi when lo[0] is set, then shift the 65-bit {carry, hi, lo} right by one.
    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
    assign w_mul_hi = w_madd[32:1];
    assign w_mul_lo = {w_madd[0], r_lo[31:1]};

    // Divide step: hi holds the partial remainder and lo shifts the dividend out / the quotient in.
    // When the divisor is zero the trial subtract always succeeds.
    // The quotient then fills with ones and the remainder ends up equal to the dividend.
    // The difference is below 2^32 whenever it is kept, so 32-bit wrap arithmetic is exact.
    assign w_rem_sh = {r_hi, r_lo[31]};
    assign w_dok    = (w_rem_sh >= {1'b0, r_b});
    assign w_dsub   = w_rem_sh[31:0] - r_b;
    assign w_div_hi = w_dok ? w_dsub : w_rem_sh[31:0];
    assign w_div_lo = {r_lo[30:0], w_dok};

    assign w_hi_nxt = r_op[1] ? w_div_hi : w_mul_hi;
    assign w_lo_nxt = r_op[1] ? w_div_lo : w_mul_lo;
    // MULHU and REMU take the high half, while MUL and DIVU take the low half.
    assign w_result = r_op[0] ? w_hi_nxt : w_lo_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: accept only in IDLE, leave BUSY after 32 steps, DONE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered write port.
    // The write-port registers clear on every edge except the one that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_dest      <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_reg_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            r_reg_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_a    <= rs1_val;
                        r_b    <= rs2_val;
                        r_dest <= dest_addr;
                        r_cnt  <= '0;
                        r_hi   <= '0;
                        r_lo   <= op[1] ? rs1_val : rs2_val;
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_reg_write <= (r_dest != 5'd0);
                        r_rd_addr   <= r_dest;
                        r_rd_data   <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign reg_write = r_reg_write;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  dest_addr;
    logic        busy, reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .dest_addr (dest_addr),
        .busy      (busy),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed directly from the operation definitions.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, got, exp);
        end
    endtask

    task automatic scramble(input bit keep);
        start     = keep ? 1'b1 : 1'($urandom);
        op        = 2'($urandom);
        rs1_val   = $urandom;
        rs2_val   = $urandom;
        dest_addr = 5'($urandom);
    endtask

    // Called at a negedge, with the unit idle.
    // Sample j is taken at the negedge after acceptance edge E0 plus j edges:
    // busy is expected for samples 0..32 and the write at sample 32.
    // Inputs are scrambled while the op is in flight, and start may toggle then.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input bit keep);
        logic [31:0] exp;
        exp       = ref_res(o, a, b);
        start     = 1'b1;
        op        = o;
        rs1_val   = a;
        rs2_val   = b;
        dest_addr = d;
        @(posedge clk);
        for (int j = 0; j <= 33; j++) begin
            @(negedge clk);
            chk("busy", j, 32'(busy), 32'(j <= 32));
            chk("reg_write", j, 32'(reg_write), 32'((j == 32) && (d != 0)));
            chk("rd_addr", j, 32'(rd_addr), (j == 32) ? 32'(d) : 32'd0);
            if (!((j == 32) && (d == 0)))
                chk("rd_data", j, rd_data, (j == 32) ? exp : 32'd0);
            if (j < 33) scramble(keep);
        end
        if (!keep) start = 1'b0;
    endtask

    // Starts an op and asserts rst so that it lands on edge E(abort_at).
    // Afterwards the unit must be idle and must never write.
    task automatic run_abort(input int abort_at);
        start     = 1'b1;
        op        = 2'd2;
        rs1_val   = 32'd1000;
        rs2_val   = 32'd3;
        dest_addr = 5'd9;
        @(posedge clk);
        for (int j = 0; j < abort_at; j++) begin
            @(negedge clk);
            scramble(1'b0);
            dest_addr = 5'd9;
        end
        chk("busy_pre_abort", abort_at, 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", abort_at, 32'(busy), 32'd0);
        chk("abort_wr", abort_at, 32'(reg_write), 32'd0);
        chk("abort_data", abort_at, rd_data, 32'd0);
        chk("abort_addr", abort_at, 32'(rd_addr), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort_nowrite", k, 32'(reg_write), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 2'd0;
        rs1_val = 32'd5; rs2_val = 32'd6; dest_addr = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state; start held with rst must not be accepted.
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_wr", 0, 32'(reg_write), 32'd0);
        chk("rst_addr", 0, 32'(rd_addr), 32'd0);
        chk("rst_data", 0, rd_data, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 0, 32'(busy), 32'd0);

        // Directed cases.
        run_op(2'd0, 32'h0000_1234, 32'h0000_0010, 5'd5, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
        run_op(2'd2, 32'd100, 32'd7, 5'd1, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 5'd2, 1'b0);
        run_op(2'd2, 32'hDEAD_BEEF, 32'd0, 5'd31, 1'b0);
        run_op(2'd3, 32'hDEAD_BEEF, 32'd0, 5'd30, 1'b0);
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0);
        run_op(2'd3, 32'd5, 32'd9, 5'd4, 1'b0);

        // start held high back-to-back: one write every 34 cycles.
        for (int i = 0; i < 4; i++)
            run_op(2'($urandom), $urandom, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom,
                   5'($urandom_range(1, 31)), 1'b1);
        start = 1'b0;
        @(negedge clk);

        // Random operations, including zero destination and small divisors.
        for (int i = 0; i < 10; i++)
            run_op(2'($urandom), $urandom, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom,
                   ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 1'b0);

        // Reset during BUSY at step 20, then reset on the edge that would enter DONE.
        run_abort(20);
        run_op(2'd2, 32'd1000, 32'd3, 5'd9, 1'b0);
        run_abort(32);
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 5'd11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
